div_sign_restore: RTL and testbench

//  Sign-restore stage at the output of the mul_div divider: the inverse of operand magnitude extraction.

---
 rtl/div_sign_restore_pkg.sv | 31 +++
 rtl/div_sign_restore_if.sv | 37 +++
 rtl/div_sign_restore_cond_negate.sv | 13 +
 rtl/div_sign_restore.sv | 150 +++++++++++++++
 tb/tb_div_sign_restore.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_sign_restore_pkg.sv
// Shared constants and helpers for the mul_div sign-restore stage.
// Holds the default width, the constant patterns and the special-case classifier.
package div_sign_restore_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Which special-case result, if any, replaces the sign-restored magnitudes.
    typedef enum logic [1:0] {
        EXC_NONE = 2'd0,
        EXC_DIV0 = 2'd1,
        EXC_OVF  = 2'd2
    } exc_e;

    // Divide-by-zero outranks overflow; overflow only exists for signed ops.
    function automatic exc_e exc_kind(input logic div_by_zero,
                                      input logic overflow,
                                      input logic is_signed);
        exc_e kind;
        kind = EXC_NONE;
        if (div_by_zero) begin
            kind = EXC_DIV0;
        end else if (overflow && is_signed) begin
            kind = EXC_OVF;
        end
        return kind;
    endfunction

endpackage

// File: rtl/div_sign_restore_if.sv
// Input beat and result beat bundle between the divider core, the sign-restore
// stage and the mul_div result mux; master drives inputs, slave is the stage.
interface div_sign_restore_if #(
    parameter int DATA_WIDTH = div_sign_restore_pkg::DATA_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  is_signed;
    logic                  dividend_neg;
    logic                  divisor_neg;
    logic                  div_by_zero;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] dividend_raw;
    logic [DATA_WIDTH-1:0] quotient_mag;
    logic [DATA_WIDTH-1:0] remainder_mag;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  out_exc;

    modport master (
        output in_valid, is_signed, dividend_neg, divisor_neg,
               div_by_zero, overflow, dividend_raw, quotient_mag, remainder_mag,
               out_ready,
        input  in_ready, out_valid, quotient, remainder, out_exc
    );

    modport slave (
        input  in_valid, is_signed, dividend_neg, divisor_neg,
               div_by_zero, overflow, dividend_raw, quotient_mag, remainder_mag,
               out_ready,
        output in_ready, out_valid, quotient, remainder, out_exc
    );

endinterface

// File: rtl/div_sign_restore_cond_negate.sv
// cond_negate: two's-complement negate of x when n is set, modulo 2^DATA_WIDTH.
// The most negative magnitude maps onto itself; no overflow indication is produced.
module cond_negate #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] x,
    input  logic                  n,
    output logic [DATA_WIDTH-1:0] y
);

    assign y = (x ^ {DATA_WIDTH{n}}) + DATA_WIDTH'(n);

endmodule

// File: rtl/div_sign_restore.sv
// div_sign_restore: 2-stage valid/ready stage turning divider magnitudes into DIV/DIVU/REM/REMU results.
// Special-case results (div-by-zero, signed overflow) exist only with DIV_SIGN_RESTORE_EXCEPTION_EN defined.
module div_sign_restore #(
    parameter int DATA_WIDTH = div_sign_restore_pkg::DATA_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    div_sign_restore_if.slave  bus
);
    import div_sign_restore_pkg::*;

    typedef struct packed {
`ifdef DIV_SIGN_RESTORE_EXCEPTION_EN
        exc_e                  exc;
        logic [DATA_WIDTH-1:0] dividend;
`endif
        logic                  q_neg;
        logic                  r_neg;
        logic [DATA_WIDTH-1:0] q_mag;
        logic [DATA_WIDTH-1:0] r_mag;
    } s1_t;

    s1_t                   s1_d;
    s1_t                   s1_q;
    logic                  s1_valid;
    logic                  s2_valid;
    logic                  s1_adv;
    logic                  s2_adv;
    logic                  in_fire;

    logic [DATA_WIDTH-1:0] q_signed;
    logic [DATA_WIDTH-1:0] r_signed;
    logic [DATA_WIDTH-1:0] q_next;
    logic [DATA_WIDTH-1:0] r_next;
    logic                  exc_next;
    logic [DATA_WIDTH-1:0] q_r;
    logic [DATA_WIDTH-1:0] r_r;
    logic                  exc_r;

    // Each stage moves when its downstream slot is empty or being drained.
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;
    assign in_fire      = bus.in_valid && s1_adv;

    // S1 payload: capture magnitudes and fold the operand signs into negate flags.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch behind.
        s1_d       = '0;
        s1_d.q_neg = bus.is_signed & (bus.dividend_neg ^ bus.divisor_neg);
        s1_d.r_neg = bus.is_signed & bus.dividend_neg;
        s1_d.q_mag = bus.quotient_mag;
        s1_d.r_mag = bus.remainder_mag;
`ifdef DIV_SIGN_RESTORE_EXCEPTION_EN
        s1_d.dividend = bus.dividend_raw;
        s1_d.exc      = exc_kind(bus.div_by_zero, bus.overflow, bus.is_signed);
`endif
    end

`ifndef DIV_SIGN_RESTORE_EXCEPTION_EN
    logic unused_exc_inputs;
    assign unused_exc_inputs = ^{bus.div_by_zero, bus.overflow, bus.dividend_raw};
`endif

    // NOTE: payload registers carry no reset; s1_valid alone decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_q <= s1_d;
        end
    end

    cond_negate #(.DATA_WIDTH(DATA_WIDTH)) u_neg_quotient (
        .x (s1_q.q_mag),
        .n (s1_q.q_neg),
        .y (q_signed)
    );

    cond_negate #(.DATA_WIDTH(DATA_WIDTH)) u_neg_remainder (
        .x (s1_q.r_mag),
        .n (s1_q.r_neg),
        .y (r_signed)
    );

    // S2 result select: special cases override the sign-restored magnitudes.
    always_comb begin
        q_next   = q_signed;
        r_next   = r_signed;
        exc_next = 1'b0;
`ifdef DIV_SIGN_RESTORE_EXCEPTION_EN
        unique case (s1_q.exc)
            EXC_DIV0: begin
                q_next   = '1;
                r_next   = s1_q.dividend;
                exc_next = 1'b1;
            end
            EXC_OVF: begin
                q_next   = s1_q.dividend;
                r_next   = '0;
                exc_next = 1'b1;
            end
            default: begin
                q_next   = q_signed;
                r_next   = r_signed;
                exc_next = 1'b0;
            end
        endcase
`endif
    end

    // Reset drops every in-flight beat; the visible outputs also clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            q_r      <= '0;
            r_r      <= '0;
            exc_r    <= 1'b0;
        end else begin
            // NOTE: state updates are non-blocking so both stages shift off the same pre-edge values.
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    q_r   <= q_next;
                    r_r   <= r_next;
                    exc_r <= exc_next;
                end
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.quotient  = q_r;
    assign bus.remainder = r_r;
    assign bus.out_exc   = exc_r;

    // A stalled result must not change under the consumer.
    a_hold_stable: assert property (
        @(posedge clk) disable iff (!reset_n)
        (s2_valid && !bus.out_ready) |=> (s2_valid && $stable(q_r) && $stable(r_r) && $stable(exc_r))
    );

    a_no_accept_when_full: assert property (
        @(posedge clk) disable iff (!reset_n)
        (s1_valid && s2_valid && !bus.out_ready) |-> !bus.in_ready
    );

endmodule

// File: tb/tb_div_sign_restore.sv
// Self-checking bench for div_sign_restore: scoreboard queue filled at input accept,
// drained by a monitor on the falling edge; scenario tasks run in sequence.
module tb_div_sign_restore;
    import div_sign_restore_pkg::*;

`ifdef DIV_SIGN_RESTORE_EXCEPTION_EN
    localparam logic EXC_ON = 1'b1;
`else
    localparam logic EXC_ON = 1'b0;
`endif

    typedef struct packed {
        logic        is_signed;
        logic        dn;
        logic        dv;
        logic        dz;
        logic        ov;
        logic [31:0] raw;
        logic [31:0] qm;
        logic [31:0] rm;
    } beat_t;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t mon_got;
    exp_t mon_want;

    div_sign_restore_if #(.DATA_WIDTH(32)) bus ();

    div_sign_restore #(.DATA_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Monitor: a beat transfers on the next rising edge when valid && ready here.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            mon_got = {bus.quotient, bus.remainder, bus.out_exc};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got q=%h r=%h exc=%b, required no beat",
                         mon_got.q, mon_got.r, mon_got.exc);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got !== mon_want) begin
                    errors++;
                    $display("FAIL result: got q=%h r=%h exc=%b, required q=%h r=%h exc=%b",
                             mon_got.q, mon_got.r, mon_got.exc, mon_want.q, mon_want.r, mon_want.exc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input beat_t b);
        exp_t e;
        logic qn;
        logic rn;
        qn    = b.is_signed && (b.dn != b.dv);
        rn    = b.is_signed && b.dn;
        e.q   = qn ? (32'd0 - b.qm) : b.qm;
        e.r   = rn ? (32'd0 - b.rm) : b.rm;
        e.exc = 1'b0;
`ifdef DIV_SIGN_RESTORE_EXCEPTION_EN
        if (b.dz) begin
            e = {ALL_ONES, b.raw, 1'b1};
        end else if (b.ov && b.is_signed) begin
            e = {b.raw, 32'd0, 1'b1};
        end
`endif
        return e;
    endfunction

    task automatic apply(input beat_t b);
        bus.is_signed     = b.is_signed;
        bus.dividend_neg  = b.dn;
        bus.divisor_neg   = b.dv;
        bus.div_by_zero   = b.dz;
        bus.overflow      = b.ov;
        bus.dividend_raw  = b.raw;
        bus.quotient_mag  = b.qm;
        bus.remainder_mag = b.rm;
    endtask

    // Called and returns just after a rising edge; returns right after the accepting edge.
    task automatic drive_beat(input beat_t b, input exp_t e);
        int  waited;
        bit  done;
        waited = 0;
        done   = 1'b0;
        apply(b);
        bus.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end else if (++waited > 60) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed %b, required 1", bus.in_ready);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || bus.out_valid) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats outstanding, required 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        apply('0);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid_low: got %b, required 0", bus.out_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_exc} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b exc=%b, required 0 0", bus.out_valid, bus.out_exc);
        end
        checks++;
        if ({bus.quotient, bus.remainder} !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: got q=%h r=%h, required 0 0", bus.quotient, bus.remainder);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_sign_rule();
        // -7 / 2 signed, then the same magnitudes unsigned.
        drive_beat('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd3, 32'd1},
                   '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out_valid=%b one clk after accept, required 0", bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_due: got out_valid=%b two clk after accept, required 1", bus.out_valid);
        end
        @(posedge clk);
        #1;
        drive_beat('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd3, 32'd1},
                   '{32'd3, 32'd1, 1'b0});
        wait_drain("sign_rule");
    endtask

    task automatic test_special_cases();
        // 5 / 0: divider core reports all-ones quotient, remainder = dividend.
        drive_beat('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, ALL_ONES, 32'd5},
                   '{ALL_ONES, 32'd5, EXC_ON});
        // -2^31 / -1 signed overflow.
        drive_beat('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, MIN_NEG, MIN_NEG, 32'd0},
                   '{MIN_NEG, 32'd0, EXC_ON});
        // Most-negative magnitude negates onto itself in both lanes.
        drive_beat('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, MIN_NEG, 32'd0},
                   '{MIN_NEG, 32'd0, 1'b0});
        drive_beat('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd2, MIN_NEG},
                   '{32'd2, MIN_NEG, 1'b0});
        wait_drain("special");
    endtask

    task automatic test_backpressure();
        beat_t b3;
        bus.out_ready = 1'b0;
        drive_beat('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd10, 32'd4},
                   '{32'hFFFF_FFF6, 32'd4, 1'b0});
        drive_beat('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd20, 32'd6},
                   '{32'd20, 32'd6, 1'b0});
        b3 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd30, 32'd8};
        apply(b3);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready_%0d: got %b, required 0", i, bus.in_ready);
            end
            checks++;
            if ({bus.out_valid, bus.quotient, bus.remainder} !== {1'b1, 32'hFFFF_FFF6, 32'd4}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got valid=%b q=%h r=%h, required 1 fffffff6 00000004",
                         i, bus.out_valid, bus.quotient, bus.remainder);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_in_ready: got %b, required 1", bus.in_ready);
        end else begin
            exp_q.push_back('{32'hFFFF_FFE2, 32'hFFFF_FFF8, 1'b0});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_drain_rate_%0d: got out_valid=%b, required 1", i, bus.out_valid);
            end
        end
        @(posedge clk);
        #1;
        wait_drain("backpressure");
    endtask

    task automatic test_back_to_back();
        bit    stop;
        beat_t b;
        stop = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    b.is_signed = 1'($urandom_range(0, 1));
                    b.dn        = 1'($urandom_range(0, 1));
                    b.dv        = 1'($urandom_range(0, 1));
                    b.dz        = ($urandom_range(0, 7) == 0);
                    b.ov        = ($urandom_range(0, 7) == 0);
                    b.raw       = $urandom();
                    b.qm        = $urandom();
                    b.rm        = (i % 5 == 0) ? MIN_NEG : $urandom();
                    drive_beat(b, model(b));
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive_beat('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd7, 32'd1}, '{32'd7, 32'd1, 1'b0});
        drive_beat('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd8, 32'd2}, '{32'd8, 32'd2, 1'b0});
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_full: got out_valid=%b, required 1", bus.out_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.quotient} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL mid_reset_clear: got valid=%b q=%h, required 0 00000000",
                     bus.out_valid, bus.quotient);
        end
        exp_q.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle_%0d: got out_valid=%b, required 0", i, bus.out_valid);
            end
        end
        @(posedge clk);
        #1;
        drive_beat('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd9, 32'd0}, '{32'hFFFF_FFF7, 32'd0, 1'b0});
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_early: got out_valid=%b, required 0", bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_due: got out_valid=%b, required 1", bus.out_valid);
        end
        @(posedge clk);
        #1;
        wait_drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_sign_rule();
        test_special_cases();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
